wash_sequencer: RTL and testbench



---
 rtl/wash_pkg.sv | 14 +
 rtl/wash_phase_timer.sv | 16 +
 rtl/wash_sequencer.sv | 104 ++++++++++
 tb/tb_wash_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// wash_pkg: shared phase encoding, time/level widths, level clamp and saturating increment for the wash sequencer
package wash_pkg;
  localparam int TIME_W = 6;
  localparam int LEVEL_W = 4;
  localparam logic [LEVEL_W-1:0] LEVEL_MIN = 4'd1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd9;
  typedef enum logic [2:0] {IDLE = 3'd0, FILL, WASH, DRAIN, SPIN, DONE, OFF} phase_t;
  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] l);
    return l < LEVEL_MIN ? LEVEL_MIN : l > LEVEL_MAX ? LEVEL_MAX : l;
  endfunction
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/wash_phase_timer.sv
// wash_phase_timer: loadable saturating down-counter; ports clk, reset (async active-low), load/load_val, en (decrement), count, zero
module wash_phase_timer import wash_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              en,
  output logic [TIME_W-1:0] count,
  output logic              zero
);
  assign zero = count == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (load) count <= load_val;
    else if (en && !zero) count <= count - 1'b1;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: tick-paced fill/wash/drain/spin/done/off program controller (clk, reset async active-low, tick, start, level_sel -> water_level, time_now, time_all, if_finish, counter_power, power_off, phase, paused, valve_in, valve_out, motor_on); optional pause via WASH_SEQ_PAUSE_EN
module wash_sequencer import wash_pkg::*; #(
  parameter int WASH_T  = 20,
  parameter int SPIN_T  = 10,
  parameter int POWER_T = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic [LEVEL_W-1:0] level_sel,
  output logic [LEVEL_W-1:0] water_level,
  output logic [TIME_W-1:0]  time_now,
  output logic [TIME_W-1:0]  time_all,
  output logic               if_finish,
  output logic [LEVEL_W-1:0] counter_power,
  output logic               power_off,
  output logic [2:0]         phase,
  output logic               paused,
  output logic               valve_in,
  output logic               valve_out,
  output logic               motor_on
);
  phase_t state;
  logic [LEVEL_W-1:0] target, lvl;
  logic [TIME_W-1:0] cnt, tmr_val;
  logic zero, acc, last, tmr_load, tmr_en;
  assign lvl = clamp_level(level_sel);
  assign acc = tick && !start && !paused;
  assign last = zero || cnt == TIME_W'(1);
  // the next phase's timer is loaded on the final tick of the current one, so it is full on entry
  assign tmr_load = acc && ((state == FILL && water_level + 1'b1 >= target) ||
                            (state == DRAIN && water_level <= LEVEL_W'(1)) ||
                            (state == SPIN && last));
  assign tmr_val = state == FILL ? TIME_W'(WASH_T) : state == DRAIN ? TIME_W'(SPIN_T) : TIME_W'(POWER_T);
  assign tmr_en = acc && (state == WASH || state == SPIN || state == DONE);
  wash_phase_timer u_timer (
    .clk(clk), .reset(reset), .load(tmr_load), .load_val(tmr_val), .en(tmr_en), .count(cnt), .zero(zero)
  );
`ifdef WASH_SEQ_PAUSE_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) paused <= 1'b0;
    else paused <= (state == FILL || state == WASH || state == DRAIN || state == SPIN) && (start ? !paused : paused);
`else
  assign paused = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      target <= '0;
      water_level <= '0;
      time_now <= '0;
      time_all <= '0;
    end else begin
      case (state)
        IDLE, DONE:
          if (start) begin
            state <= FILL;
            target <= lvl;
            water_level <= '0;
            time_now <= '0;
            time_all <= TIME_W'({lvl, 1'b0}) + TIME_W'(WASH_T + SPIN_T);
          end else if (state == DONE && acc && last) state <= OFF;
        FILL:
          if (acc) begin
            water_level <= water_level + 1'b1;
            time_now <= sat_inc(time_now);
            if (water_level + 1'b1 >= target) state <= WASH;
          end
        WASH:
          if (acc) begin
            time_now <= sat_inc(time_now);
            if (last) state <= DRAIN;
          end
        DRAIN:
          if (acc) begin
            water_level <= water_level == '0 ? water_level : water_level - 1'b1;
            time_now <= sat_inc(time_now);
            if (water_level <= LEVEL_W'(1)) state <= SPIN;
          end
        SPIN:
          if (acc) begin
            time_now <= sat_inc(time_now);
            if (last) state <= DONE;
          end
        OFF:
          if (start) begin
            state <= IDLE;
            target <= '0;
            water_level <= '0;
            time_now <= '0;
            time_all <= '0;
          end
        default: state <= IDLE;
      endcase
    end
  assign phase = state;
  assign if_finish = state == DONE || state == OFF;
  assign power_off = state == OFF;
  assign counter_power = state == DONE ? cnt[LEVEL_W-1:0] : '0;
  assign valve_in = !paused && state == FILL;
  assign valve_out = !paused && (state == DRAIN || state == SPIN);
  assign motor_on = !paused && (state == WASH || state == SPIN);
endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: randomized and directed bench against a tick-count model of the wash program
module tb_wash_sequencer;
  localparam int W = 20;
  localparam int S = 10;
  localparam int P = 9;
`ifdef WASH_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, start = 1'b0;
  logic [3:0] level_sel = 4'd0;
  logic [3:0] water_level, counter_power;
  logic [5:0] time_now, time_all;
  logic [2:0] phase;
  logic if_finish, power_off, paused, valve_in, valve_out, motor_on;
  int errors = 0, checks = 0;
  int m_mode = 0, m_t = 0, m_tgt = 0;
  bit m_p = 1'b0;

  wash_sequencer #(.WASH_T(W), .SPIN_T(S), .POWER_T(P)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .level_sel(level_sel),
    .water_level(water_level), .time_now(time_now), .time_all(time_all), .if_finish(if_finish),
    .counter_power(counter_power), .power_off(power_off), .phase(phase), .paused(paused),
    .valve_in(valve_in), .valve_out(valve_out), .motor_on(motor_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input int e);
    checks++;
    if (a !== 32'(e)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  // Program model: everything derives from the number of accepted ticks m_t since start.
  function automatic int e_tot();
    return 2 * m_tgt + W + S;
  endfunction
  function automatic int e_phase();
    if (m_mode == 0) return 0;
    if (m_t < m_tgt) return 1;
    if (m_t < m_tgt + W) return 2;
    if (m_t < 2 * m_tgt + W) return 3;
    if (m_t < e_tot()) return 4;
    if (m_t < e_tot() + P) return 5;
    return 6;
  endfunction
  function automatic int e_level();
    int ph = e_phase();
    return ph == 1 ? m_t : ph == 2 ? m_tgt : ph == 3 ? 2 * m_tgt + W - m_t : 0;
  endfunction
  function automatic int e_tnow();
    return m_mode == 0 ? 0 : (m_t < e_tot() ? m_t : e_tot());
  endfunction
  function automatic int e_tall();
    return m_mode == 0 ? 0 : e_tot();
  endfunction
  function automatic int e_cp();
    return e_phase() == 5 ? P - (m_t - e_tot()) : 0;
  endfunction

  task automatic start_prog(input logic [3:0] ls);
    m_tgt = ls == 0 ? 1 : (ls > 9 ? 9 : int'(ls));
    m_mode = 1;
    m_t = 0;
    m_p = 1'b0;
  endtask

  task automatic mdl(input bit st, input bit tk, input logic [3:0] ls);
    if (!reset) begin
      m_mode = 0; m_t = 0; m_tgt = 0; m_p = 1'b0;
    end else if (m_mode == 0) begin
      if (st) start_prog(ls);
    end else if (m_t >= e_tot() + P) begin
      if (st) begin m_mode = 0; m_t = 0; m_tgt = 0; end
    end else if (m_t >= e_tot()) begin
      if (st) start_prog(ls);
      else if (tk) m_t++;
    end else begin
      if (st) m_p = PAUSE_EN ? !m_p : m_p;
      else if (tk && !m_p) m_t++;
    end
  endtask

  task automatic cyc(input bit st, input bit tk, input logic [3:0] ls);
    start = st; tick = tk; level_sel = ls;
    @(posedge clk);
    mdl(st, tk, ls);
    #1;
    start = 1'b0; tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 4'd0);
  endtask

  always @(negedge clk) begin
    chk("phase", phase, e_phase());
    chk("water_level", water_level, e_level());
    chk("time_now", time_now, e_tnow());
    chk("time_all", time_all, e_tall());
    chk("if_finish", if_finish, e_phase() >= 5);
    chk("counter_power", counter_power, e_cp());
    chk("power_off", power_off, e_phase() == 6);
    chk("paused", paused, m_p);
    chk("valve_in", valve_in, e_phase() == 1 && !m_p);
    chk("valve_out", valve_out, (e_phase() == 3 || e_phase() == 4) && !m_p);
    chk("motor_on", motor_on, (e_phase() == 2 || e_phase() == 4) && !m_p);
  end

  initial begin
    #12 reset = 1'b1;
    chk("rst_phase", phase, 0);
    chk("rst_tall", time_all, 0);
    cyc(1'b1, 1'b0, 4'd3);
    chk("l3_fill", phase, 1);
    chk("l3_tall", time_all, 36);
    chk("mdl_tall36", e_tall(), 36);
    chk("l3_lvl0", water_level, 0);
    for (int i = 1; i <= 3; i++) begin
      ticks(1);
      chk("l3_fill_lvl", water_level, i);
    end
    chk("l3_wash", phase, 2);
    ticks(W);
    chk("l3_drain", phase, 3);
    chk("l3_drain_t", time_now, 23);
    ticks(3);
    chk("l3_spin", phase, 4);
    chk("l3_spin_lvl", water_level, 0);
    ticks(S);
    chk("l3_done", phase, 5);
    chk("l3_done_t", time_now, 36);
    chk("l3_done_fin", if_finish, 1);
    chk("l3_done_cp", counter_power, 9);
    chk("mdl_cp9", e_cp(), 9);
    ticks(P - 1);
    chk("l3_cp1", counter_power, 1);
    chk("l3_po0", power_off, 0);
    ticks(1);
    chk("l3_off", power_off, 1);
    chk("l3_off_fin", if_finish, 1);
    cyc(1'b1, 1'b0, 4'd5);
    chk("off_idle", phase, 0);
    chk("off_po", power_off, 0);
    cyc(1'b1, 1'b0, 4'd0);
    chk("l0_tall", time_all, 32);
    ticks(6);
    chk("l0_wash", phase, 2);
    #2 reset = 1'b0;
    mdl(1'b0, 1'b0, 4'd0);
    #1;
    chk("arst_phase", phase, 0);
    chk("arst_tall", time_all, 0);
    chk("arst_motor", motor_on, 0);
    ticks(2);
    #2 reset = 1'b1;
    ticks(3);
    chk("post_rst_idle", phase, 0);
    cyc(1'b1, 1'b1, 4'd12);
    chk("st_tk_fill", phase, 1);
    chk("st_tk_lvl", water_level, 0);
    chk("st_tk_tnow", time_now, 0);
    chk("l12_tall", time_all, 48);
    ticks(11);
    chk("l12_wash_t", time_now, 11);
    cyc(1'b1, 1'b0, 4'd0);
    ticks(5);
`ifdef WASH_SEQ_PAUSE_EN
    chk("pause_t", time_now, 11);
    chk("pause_motor", motor_on, 0);
    chk("pause_flag", paused, 1);
    cyc(1'b1, 1'b0, 4'd0);
    chk("resume_motor", motor_on, 1);
    ticks(1);
    chk("resume_t", time_now, 12);
`else
    chk("nopause_t", time_now, 16);
    chk("nopause_motor", motor_on, 1);
`endif
    for (int i = 0; i < 20000; i++)
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
